imem_loader: RTL

- Writer side of the instruction path: receives a byte stream, packs it into 32-bit instruction words, writes them sequentially into instruction memory, then releases the processor from reset.
- The processor fetch and control logic is the reader of those same words.
- Sits between the host/UART byte source and the imem write port; owns the processor's reset line during loading.

---
 rtl/imem_loader.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Packs a big-endian byte stream into 32-bit words, writes them into imem and then releases the processor.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing sum-of-words checksum after the end marker.
`timescale 1ns/1ps

module imem_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          MAX_WORDS  = 4096,
    parameter logic [31:0] END_MARKER = 32'hFFFF_FFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_data,
    output logic                  imem_we,
    output logic                  proc_reset,
    output logic                  load_done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSEMBLE,
        S_WRITE,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(MAX_WORDS);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    state_t      state;
    logic [31:0] word_buf;
    logic [31:0] asm_word;
    logic [1:0]  byte_idx;
    logic        xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif

    assign xfer = byte_valid && byte_ready;

    // word as it stands once the byte on byte_in is merged at the current index
    always_comb begin
        asm_word = word_buf;
        case (byte_idx)
            2'd0:    asm_word[31:24] = byte_in;
            2'd1:    asm_word[23:16] = byte_in;
            2'd2:    asm_word[15:8]  = byte_in;
            default: asm_word[7:0]   = byte_in;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            word_buf   <= '0;
            byte_idx   <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_data  <= '0;
            proc_reset <= 1'b1;
            load_done  <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    byte_ready <= 1'b1;
                    if (xfer) begin
                        word_buf <= asm_word;
                        byte_idx <= byte_idx + 2'd1;
                        state    <= S_ASSEMBLE;
                    end
                end
                S_ASSEMBLE: begin
                    if (xfer) begin
                        word_buf <= asm_word;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (asm_word == END_MARKER) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state      <= S_CHECK;
`else
                                state      <= S_DONE;
                                byte_ready <= 1'b0;
                                load_done  <= 1'b1;
                                proc_reset <= 1'b0;
`endif
                            end else if (word_count == MAX_CNT) begin
                                state      <= S_ERROR;
                                byte_ready <= 1'b0;
                                error      <= 1'b1;
                            end else begin
                                state      <= S_WRITE;
                                byte_ready <= 1'b0;
                                imem_we    <= 1'b1;
                                imem_addr  <= word_count[ADDR_WIDTH-1:0];
                                imem_data  <= asm_word;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + CNT_ONE;
                    byte_idx   <= '0;
                    byte_ready <= 1'b1;
                    state      <= S_ASSEMBLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum       <= csum + imem_data;
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        word_buf <= asm_word;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            byte_ready <= 1'b0;
                            if (asm_word == csum) begin
                                state      <= S_DONE;
                                load_done  <= 1'b1;
                                proc_reset <= 1'b0;
                            end else begin
                                state <= S_ERROR;
                                error <= 1'b1;
                            end
                        end
                    end
                end
`endif
                S_DONE, S_ERROR: begin
                    // imem contents are deliberately left intact on re-arm
                    if (start) begin
                        state      <= S_IDLE;
                        byte_ready <= 1'b1;
                        byte_idx   <= '0;
                        proc_reset <= 1'b1;
                        load_done  <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
